// File: rtl/mpu_irq_ctrl.sv
// rtl/mpu_irq_ctrl.sv - interrupt arbiter/controller for the MPU
// Serves masked level requests one at a time, lowest index first, with EOI/ack handshake.
module mpu_irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int CLR_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       irq_out,
    output logic [2:0] irq_id,
    output logic [7:0] irq_ack_out
);
    typedef enum logic [1:0] {IDLE, ACTIVE, ACK, CLRWAIT} state_t;

    localparam logic [3:0] TMO = CLR_TIMEOUT[3:0];

    state_t     state_q;
    logic [7:0] mask_q;
    logic [7:0] cpu_rdata_q;
    logic       irq_out_q;
    logic [2:0] irq_id_q;
    logic [7:0] irq_ack_out_q;
    logic [3:0] wait_q;
    logic [3:0] wait_d;
    logic [7:0] pending;
    logic [2:0] lowest;
    logic [7:0] rd_mux;
    logic       eoi_wr;
    logic       busy;

    assign pending = irq_in & mask_q;
    assign eoi_wr  = cpu_wr && (cpu_addr == 2'd3);
    assign busy    = (state_q != IDLE);
    assign wait_d  = wait_q + 4'd1;

    // Scan downward so the last hit, i.e. the lowest index, wins.
    always_comb begin
        lowest = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) lowest = 3'(i);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (cpu_addr)
            2'd0:    rd_mux = mask_q;
            2'd1:    rd_mux = pending;
            2'd2:    rd_mux = {busy, 4'b0000, irq_id_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            cpu_rdata_q   <= '0;
            irq_out_q     <= 1'b0;
            irq_id_q      <= '0;
            irq_ack_out_q <= '0;
            wait_q        <= '0;
        end else begin
            if (cpu_wr && (cpu_addr == 2'd0)) mask_q <= cpu_wdata;
            if (cpu_rd) cpu_rdata_q <= rd_mux;
            case (state_q)
                IDLE: begin
                    if (pending != 8'd0) begin
                        state_q   <= ACTIVE;
                        irq_id_q  <= lowest;
                        irq_out_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (eoi_wr) begin
                        state_q       <= ACK;
                        irq_out_q     <= 1'b0;
                        irq_ack_out_q <= 8'd1 << irq_id_q;
                    end
                end
                ACK: begin
                    state_q       <= CLRWAIT;
                    irq_ack_out_q <= '0;
                    wait_q        <= '0;
                end
                CLRWAIT: begin
                    // A source still high at timeout is simply re-arbitrated from IDLE.
                    wait_q <= wait_d;
                    if (!irq_in[irq_id_q] || (wait_d == TMO)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign irq_out     = irq_out_q;
    assign irq_id      = irq_id_q;
    assign irq_ack_out = irq_ack_out_q;
endmodule

// File: tb/tb_mpu_irq_ctrl.sv
// tb/tb_mpu_irq_ctrl.sv - self-checking bench for mpu_irq_ctrl
module tb_mpu_irq_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       irq_out;
    logic [2:0] irq_id;
    logic [7:0] irq_ack_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 serving, 2 acking, 3 waiting for source release.
    int         m_phase;
    int         m_waited;
    logic [7:0] m_mask;
    logic [7:0] m_rdata;
    logic [2:0] m_id;

    always #5 clk = ~clk;

    mpu_irq_ctrl #(.NUM_IRQ(8), .CLR_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .irq_out    (irq_out),
        .irq_id     (irq_id),
        .irq_ack_out(irq_ack_out)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int         n_phase  = m_phase;
        int         n_waited = m_waited;
        logic [7:0] n_mask   = m_mask;
        logic [7:0] n_rdata  = m_rdata;
        logic [2:0] n_id     = m_id;
        logic [7:0] req;
        logic       found;
        if (reset) begin
            n_phase = 0; n_waited = 0; n_mask = 8'h00; n_rdata = 8'h00; n_id = 3'd0;
        end else begin
            req = irq_in & m_mask;
            if (cpu_rd) begin
                if (cpu_addr == 2'd0)      n_rdata = m_mask;
                else if (cpu_addr == 2'd1) n_rdata = req;
                else if (cpu_addr == 2'd2) n_rdata = {(m_phase != 0), 4'b0000, m_id};
                else                       n_rdata = 8'h00;
            end
            if (m_phase == 0) begin
                found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (req[i] && !found) begin
                        found = 1'b1;
                        n_id  = 3'(i);
                    end
                end
                if (found) n_phase = 1;
            end else if (m_phase == 1) begin
                if (cpu_wr && cpu_addr == 2'd3) n_phase = 2;
            end else if (m_phase == 2) begin
                n_phase = 3; n_waited = 0;
            end else begin
                n_waited = m_waited + 1;
                if (!irq_in[m_id] || n_waited == 15) n_phase = 0;
            end
            if (cpu_wr && cpu_addr == 2'd0) n_mask = cpu_wdata;
        end
        @(posedge clk);
        #1;
        m_phase = n_phase; m_waited = n_waited; m_mask = n_mask; m_rdata = n_rdata; m_id = n_id;
        chk("model_rdata", cpu_rdata, m_rdata);
        chk("model_irq_out", {7'd0, irq_out}, {7'd0, (m_phase == 1)});
        chk("model_irq_id", {5'd0, irq_id}, {5'd0, m_id});
        chk("model_ack", irq_ack_out, (m_phase == 2) ? (8'd1 << m_id) : 8'd0);
    endtask

    task automatic do_wr(input logic [1:0] a, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic do_rd(input logic [1:0] a);
        cpu_rd = 1'b1; cpu_addr = a;
        step();
        cpu_rd = 1'b0;
    endtask

    initial begin
        int cnt;
        m_phase = 0; m_waited = 0; m_mask = 8'h00; m_rdata = 8'h00; m_id = 3'd0;
        reset = 1'b1; irq_in = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 2'd0; cpu_wdata = 8'h00;
        step();
        chk("reset_rdata", cpu_rdata, 8'h00);
        chk("reset_irq_out", {7'd0, irq_out}, 8'h00);
        chk("reset_ack", irq_ack_out, 8'h00);
        reset = 1'b0;

        do_wr(2'd0, 8'h5A);
        do_rd(2'd0);
        chk("mask_readback", cpu_rdata, 8'h5A);
        do_rd(2'd3);
        chk("eoi_read_zero", cpu_rdata, 8'h00);

        do_wr(2'd0, 8'hFF);
        irq_in = 8'h24;
        step();
        chk("first_id2", {5'd0, irq_id}, 8'd2);
        chk("first_irq_out", {7'd0, irq_out}, 8'd1);
        do_wr(2'd3, 8'h00);
        chk("ack_id2", irq_ack_out, 8'h04);
        step();
        chk("ack_one_cycle", irq_ack_out, 8'h00);
        irq_in = 8'h20;
        step();
        step();
        chk("second_id5", {5'd0, irq_id}, 8'd5);
        do_wr(2'd3, 8'h00);
        chk("ack_id5", irq_ack_out, 8'h20);
        irq_in = 8'h00;
        step();
        step();

        do_wr(2'd0, 8'h00);
        irq_in = 8'hFF;
        step();
        chk("masked_no_irq", {7'd0, irq_out}, 8'd0);
        do_rd(2'd1);
        chk("pending_masked", cpu_rdata, 8'h00);
        do_wr(2'd0, 8'h80);
        step();
        chk("mask80_id7", {5'd0, irq_id}, 8'd7);
        chk("mask80_irq_out", {7'd0, irq_out}, 8'd1);
        do_wr(2'd3, 8'h00);
        irq_in = 8'h00;
        step();
        step();

        do_wr(2'd3, 8'h00);
        chk("eoi_idle_no_ack", irq_ack_out, 8'h00);
        do_rd(2'd2);
        chk("status_idle", cpu_rdata, 8'h07);
        irq_in = 8'h80;
        step();
        do_wr(2'd3, 8'h00);
        step();
        do_rd(2'd2);
        chk("status_busy_clrwait", cpu_rdata, 8'h87);
        irq_in = 8'h00;
        step();
        step();

        do_wr(2'd0, 8'h08);
        irq_in = 8'h08;
        step();
        do_wr(2'd3, 8'h00);
        cnt = 0;
        while (irq_out !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk("timeout_cycles", 8'(cnt), 8'd17);
        chk("reserve_id3", {5'd0, irq_id}, 8'd3);
        do_wr(2'd3, 8'h00);
        irq_in = 8'h00;
        step();
        step();

        do_wr(2'd0, 8'h40);
        irq_in = 8'h40;
        step();
        chk("active_id6", {5'd0, irq_id}, 8'd6);
        reset = 1'b1; cpu_wr = 1'b1; cpu_addr = 2'd3;
        step();
        reset = 1'b0; cpu_wr = 1'b0;
        chk("rst_irq_out", {7'd0, irq_out}, 8'd0);
        chk("rst_irq_id", {5'd0, irq_id}, 8'd0);
        chk("rst_ack", irq_ack_out, 8'h00);
        irq_in = 8'h00;
        step();
        chk("rst_no_late_ack", irq_ack_out, 8'h00);
        do_rd(2'd0);
        chk("rst_mask", cpu_rdata, 8'h00);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
            cpu_wr    = ($urandom_range(0, 5) == 0);
            cpu_rd    = ($urandom_range(0, 3) == 0);
            cpu_addr  = 2'($urandom);
            cpu_wdata = 8'($urandom);
            reset     = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
